// File: rtl/dualmem_bytewise_scrub.sv
// Single-clock true dual-port RAM with per-byte write enables, req/gnt/rvalid
// handshakes on both ports, optional output register, post-reset zero scrub
// and same-address write-collision flag.
module dualmem_bytewise_scrub #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int OUT_REG    = 0,
  parameter int INIT_ZERO  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    init_done_o,
  input  logic                    a_req_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic                    a_gnt_o,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  input  logic                    b_req_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic                    b_gnt_o,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    collision_o
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {ST_RESET, ST_SCRUB, ST_READY} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   scrub_addr;
  logic                    scrub_en;
  logic                    a_wr, b_wr;
  logic                    a_vld_p0, b_vld_p0;
  logic [DATA_WIDTH-1:0]   a_rdata_p0, b_rdata_p0;

  assign init_done_o = (state == ST_READY);
  assign scrub_en    = (state == ST_SCRUB);
  assign a_gnt_o     = a_req_i & init_done_o;
  assign b_gnt_o     = b_req_i & init_done_o;
  assign a_wr        = a_gnt_o & a_we_i;
  assign b_wr        = b_gnt_o & b_we_i;

  // State register: reset parks the FSM in ST_RESET until rst_ni rises
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_RESET;
    else         state <= state_next;
  end

  // Next state: optional scrub pass, then READY until the next reset
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = (INIT_ZERO != 0) ? ST_SCRUB : ST_READY;
      ST_SCRUB: if (&scrub_addr) state_next = ST_READY;
      default:  state_next = ST_READY;
    endcase
  end

  // Scrub address counter, restarts from zero on every reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       scrub_addr <= '0;
    else if (scrub_en) scrub_addr <= scrub_addr + ADDR_WIDTH'(1);
  end

  // Stage p0: response valid follows the grant edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_vld_p0 <= 1'b0;
      b_vld_p0 <= 1'b0;
    end else begin
      a_vld_p0 <= a_gnt_o;
      b_vld_p0 <= b_gnt_o;
    end
  end

  // One RAM per byte lane; each lane carries its own write enables and read port
  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] a_q, b_q;

    // Lane storage: scrub zeroes, otherwise B then A so A wins a shared address
    always_ff @(posedge clk_i) begin
      if (scrub_en) begin
        lane_mem[scrub_addr] <= '0;
      end else begin
        if (b_wr && b_be_i[g]) lane_mem[b_addr_i] <= b_wdata_i[g*8 +: 8];
        if (a_wr && a_be_i[g]) lane_mem[a_addr_i] <= a_wdata_i[g*8 +: 8];
      end
    end

    // Lane read: old contents captured on the grant edge, held otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        if (a_gnt_o) a_q <= lane_mem[a_addr_i];
        if (b_gnt_o) b_q <= lane_mem[b_addr_i];
      end
    end

    assign a_rdata_p0[g*8 +: 8] = a_q;
    assign b_rdata_p0[g*8 +: 8] = b_q;
  end

  // Stage p1: optional output register keeps rvalid and rdata aligned
  if (OUT_REG != 0) begin : g_oreg
    logic                  a_vld_p1, b_vld_p1;
    logic [DATA_WIDTH-1:0] a_rdata_p1, b_rdata_p1;

    // Output stage advances data only with a valid response so rdata holds
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_vld_p1   <= 1'b0;
        b_vld_p1   <= 1'b0;
        a_rdata_p1 <= '0;
        b_rdata_p1 <= '0;
      end else begin
        a_vld_p1 <= a_vld_p0;
        b_vld_p1 <= b_vld_p0;
        if (a_vld_p0) a_rdata_p1 <= a_rdata_p0;
        if (b_vld_p0) b_rdata_p1 <= b_rdata_p0;
      end
    end

    assign a_rvalid_o = a_vld_p1;
    assign b_rvalid_o = b_vld_p1;
    assign a_rdata_o  = a_rdata_p1;
    assign b_rdata_o  = b_rdata_p1;
  end else begin : g_noreg
    assign a_rvalid_o = a_vld_p0;
    assign b_rvalid_o = b_vld_p0;
    assign a_rdata_o  = a_rdata_p0;
    assign b_rdata_o  = b_rdata_p0;
  end

  // Collision flag: both ports wrote overlapping lanes of the same word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) collision_o <= 1'b0;
    else collision_o <= a_wr & b_wr & (a_addr_i == b_addr_i) & (|(a_be_i & b_be_i));
  end

endmodule

// File: tb/tb_dualmem_bytewise_scrub.sv
// Randomised scoreboard bench for dualmem_bytewise_scrub (64-bit, 16 words,
// output register enabled, zero scrub enabled).
module tb_dualmem_bytewise_scrub;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int OREG  = 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          init_done_o;
  logic          a_req_i, a_we_i, b_req_i, b_we_i;
  logic [7:0]    a_be_i, b_be_i;
  logic [AW-1:0] a_addr_i, b_addr_i;
  logic [DW-1:0] a_wdata_i, b_wdata_i;
  logic          a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o;
  logic [DW-1:0] a_rdata_o, b_rdata_o;
  logic          collision_o;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  bit            exp_ready = 1'b0;
  int            since_rst = 0;
  logic [DW-1:0] model [DEPTH];
  exp_t          q [2][$];
  logic [DW-1:0] last [2];
  bit            coll_due [int];
  logic [1:0]    rv;
  logic [DW-1:0] rd [2];

  dualmem_bytewise_scrub #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(OREG), .INIT_ZERO(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .init_done_o(init_done_o),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_be_i(a_be_i), .a_addr_i(a_addr_i),
    .a_wdata_i(a_wdata_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_be_i(b_be_i), .b_addr_i(b_addr_i),
    .b_wdata_i(b_wdata_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
    .collision_o(collision_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rv    = {b_rvalid_o, a_rvalid_o};
  assign rd[0] = a_rdata_o;
  assign rd[1] = b_rdata_o;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  // Byte-lane merge: lanes with enable set take the new data
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [7:0] be);
    logic [DW-1:0] m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
    return (old & ~m) | (wd & m);
  endfunction

  // Monitor: compares every response and the collision flag on the falling edge
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (q[p].size() > 0 && q[p][0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid port %0d: no response by cycle %0d, required at %0d",
                 p, cyc, q[p][0].due);
        void'(q[p].pop_front());
      end
      if (rv[p]) begin
        if (q[p].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid port %0d at cycle %0d: got rvalid=1, required 0", p, cyc);
        end else begin
          exp_t e;
          e = q[p].pop_front();
          chk(p == 0 ? "a_rdata" : "b_rdata", rd[p], e.data);
          chk(p == 0 ? "a_latency" : "b_latency", DW'(cyc), DW'(e.due));
          last[p] = e.data;
        end
      end else begin
        chk(p == 0 ? "a_rdata_hold" : "b_rdata_hold", rd[p], last[p]);
      end
    end
    chk("collision", DW'(collision_o), DW'(coll_due.exists(cyc)));
    if (coll_due.exists(cyc)) coll_due.delete(cyc);
  end

  // One clock of stimulus: drive, check grants, queue expectations, advance
  task automatic step(input logic ar, input logic aw, input logic [7:0] abe,
                      input logic [AW-1:0] aad, input logic [DW-1:0] ad,
                      input logic br, input logic bw, input logic [7:0] bbe,
                      input logic [AW-1:0] bad, input logic [DW-1:0] bd);
    bit ag, bg;
    a_req_i = ar; a_we_i = aw; a_be_i = abe; a_addr_i = aad; a_wdata_i = ad;
    b_req_i = br; b_we_i = bw; b_be_i = bbe; b_addr_i = bad; b_wdata_i = bd;
    #1;
    ag = ar && exp_ready;
    bg = br && exp_ready;
    chk("init_done", DW'(init_done_o), DW'(exp_ready));
    chk("a_gnt", DW'(a_gnt_o), DW'(ag));
    chk("b_gnt", DW'(b_gnt_o), DW'(bg));
    if (ag) q[0].push_back('{model[aad], cyc + 1 + OREG});
    if (bg) q[1].push_back('{model[bad], cyc + 1 + OREG});
    if (ag && aw && bg && bw && aad == bad && (abe & bbe) != 8'h00) coll_due[cyc + 1] = 1'b1;
    if (bg && bw) model[bad] = merge(model[bad], bd, bbe);
    if (ag && aw) model[aad] = merge(model[aad], ad, abe);
    @(posedge clk);
    #1;
    if (rst_ni && !exp_ready) begin
      since_rst++;
      if (since_rst == DEPTH + 1) begin
        exp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 8'h00, '0, '0, 0, 0, 8'h00, '0, '0);
  endtask

  task automatic rnd_step(input bit allow_write);
    step(1'($urandom), allow_write & 1'($urandom), 8'($urandom), AW'($urandom),
         {$urandom, $urandom},
         1'($urandom), allow_write & 1'($urandom), 8'($urandom), AW'($urandom),
         {$urandom, $urandom});
  endtask

  // Holds reset for n cycles, discarding anything still in flight, then releases
  task automatic do_reset(input int n);
    rst_ni = 1'b0;
    q[0].delete();
    q[1].delete();
    coll_due.delete();
    last[0] = '0;
    last[1] = '0;
    exp_ready = 1'b0;
    since_rst = 0;
    for (int i = 0; i < n; i++) idle();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    last[0] = '0;
    last[1] = '0;
    a_req_i = 0; a_we_i = 0; a_be_i = 0; a_addr_i = 0; a_wdata_i = 0;
    b_req_i = 0; b_we_i = 0; b_be_i = 0; b_addr_i = 0; b_wdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Requests during scrub are refused; reset mid-scrub restarts the scrub
    for (int i = 0; i < 7; i++) rnd_step(1'b0);
    do_reset(2);
    for (int i = 0; i < DEPTH + 3; i++) rnd_step(1'b0);

    // Every word reads zero after the scrub
    for (int i = 0; i < DEPTH; i++)
      step(1, 0, 8'h00, AW'(i), '0, 1, 0, 8'h00, AW'(DEPTH - 1 - i), '0);

    // Byte enables
    step(1, 1, 8'hFF, 4'd3, 64'h1122334455667788, 0, 0, 8'h00, '0, '0);
    step(1, 1, 8'h0F, 4'd3, 64'hAAAAAAAAAAAAAAAA, 0, 0, 8'h00, '0, '0);
    step(1, 0, 8'h00, 4'd3, '0, 0, 0, 8'h00, '0, '0);

    // Same-address write collision: A lanes win where enabled
    step(1, 1, 8'h0F, 4'd5, 64'hFFFFFFFFFFFFFFFF, 1, 1, 8'hFF, 4'd5, 64'h0);
    step(1, 0, 8'h00, 4'd5, '0, 0, 0, 8'h00, '0, '0);

    // Read during write across ports returns old data
    step(1, 1, 8'hFF, 4'd7, 64'h5, 0, 0, 8'h00, '0, '0);
    step(1, 1, 8'hFF, 4'd7, 64'h9, 1, 0, 8'h00, 4'd7, '0);
    step(0, 0, 8'h00, '0, '0, 1, 0, 8'h00, 4'd7, '0);

    // Back-to-back reads on both ports
    for (int i = 0; i < 8; i++)
      step(1, 0, 8'h00, AW'(i), '0, 1, 0, 8'h00, AW'(15 - i), '0);

    // Random traffic
    for (int i = 0; i < 400; i++) rnd_step(1'b1);

    // Reset with responses in flight, then traffic after a fresh scrub
    step(1, 0, 8'h00, 4'd1, '0, 1, 0, 8'h00, 4'd2, '0);
    do_reset(3);
    for (int i = 0; i < DEPTH + 2; i++) idle();
    for (int i = 0; i < 100; i++) rnd_step(1'b1);

    for (int i = 0; i < 4; i++) idle();
    chk("a_drained", DW'(q[0].size()), '0);
    chk("b_drained", DW'(q[1].size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
